// File: rtl/fir_sample_controller.sv
// fir_sample_controller: per-sample load/clear/MAC/store sequencer; define SAMPLE_DROP_CNT_EN to add the ignored-start counter dropped_cnt.
module fir_sample_controller #(
  parameter int NUM_TAPS = 4,
  localparam int TW = $clog2(NUM_TAPS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          data_ready,
  input  logic          overflow,
  output logic [2:0]    op,
  output logic [TW-1:0] tap_sel,
  output logic          cnt_up,
  output logic          modwait,
  output logic          err
`ifdef SAMPLE_DROP_CNT_EN
  ,
  output logic [7:0]    dropped_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, MAC, STORE, EIDLE} state_t;
  state_t state, state_d;
  logic dr_q, start, last_tap;
  logic [2:0] op_d;
  logic [TW-1:0] tap_d;
  logic cnt_d, mw_d, err_d;
  assign start = data_ready & ~dr_q;
  assign last_tap = tap_sel == TW'(NUM_TAPS - 1);
  // Outputs are decoded from the next state and registered, so they line up with state.
  always_comb begin
    state_d = state;
    tap_d = '0;
    case (state)
      IDLE, EIDLE: state_d = start ? LOAD : state;
      LOAD: state_d = CLEAR;
      CLEAR: state_d = MAC;
      MAC: begin
        state_d = overflow ? EIDLE : last_tap ? STORE : MAC;
        tap_d = (overflow || last_tap) ? '0 : tap_sel + 1'b1;
      end
      STORE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    op_d = state_d == LOAD ? 3'b001 : state_d == CLEAR ? 3'b010 :
           state_d == MAC ? 3'b011 : state_d == STORE ? 3'b100 : 3'b000;
    cnt_d = state_d == LOAD;
    mw_d = state_d inside {LOAD, CLEAR, MAC, STORE};
    err_d = state_d == EIDLE ? 1'b1 : state_d == LOAD ? 1'b0 : err;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dr_q <= 1'b0;
      op <= 3'b000;
      tap_sel <= '0;
      cnt_up <= 1'b0;
      modwait <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_d;
      dr_q <= data_ready;
      op <= op_d;
      tap_sel <= tap_d;
      cnt_up <= cnt_d;
      modwait <= mw_d;
      err <= err_d;
    end
  end
`ifdef SAMPLE_DROP_CNT_EN
  logic ignored;
  assign ignored = start & (state inside {LOAD, CLEAR, MAC, STORE});
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dropped_cnt <= 8'd0;
    else if (ignored && dropped_cnt != 8'hff) dropped_cnt <= dropped_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_fir_sample_controller.sv
// tb_fir_sample_controller: scoreboard bench; expected op/tap/cnt_up/modwait/err vectors are queued per sample and popped by a monitor.
module tb_fir_sample_controller;
  localparam int N = 4;
  logic clk = 0, reset = 0, data_ready = 0, overflow = 0;
  logic [2:0] op;
  logic [1:0] tap_sel;
  logic cnt_up, modwait, err;
`ifdef SAMPLE_DROP_CNT_EN
  logic [7:0] dropped_cnt;
`endif
  typedef struct packed {
    logic [2:0] op;
    logic [1:0] tap;
    logic       cnt;
    logic       mw;
    logic       err;
  } exp_t;
  exp_t exp_q[$];
  int n_vec = 0, n_err = 0, n_cnt = 0, exp_cnt = 0;
  logic err_prev = 0;

  fir_sample_controller #(.NUM_TAPS(N)) dut (
    .clk(clk), .reset(reset), .data_ready(data_ready), .overflow(overflow),
    .op(op), .tap_sel(tap_sel), .cnt_up(cnt_up), .modwait(modwait), .err(err)
`ifdef SAMPLE_DROP_CNT_EN
    , .dropped_cnt(dropped_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] o, input logic [1:0] t, input logic c,
                              input logic m, input logic e);
    return {o, t, c, m, e};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: any active output (non-NOP op, cnt_up, or err rising) consumes one expected vector.
  always @(negedge clk) begin
    exp_t a;
    a = {op, tap_sel, cnt_up, modwait, err};
    if (cnt_up) n_cnt++;
    if (op != 3'b000 || cnt_up || (err && !err_prev)) begin
      if (exp_q.size() == 0) check("unexpected_output", 32'(a), 32'hffff_ffff);
      else check("output_vector", 32'(a), 32'(exp_q.pop_front()));
    end else begin
      check("quiet_modwait", 32'(modwait), 32'd0);
      check("quiet_tap", 32'(tap_sel), 32'd0);
    end
    err_prev <= err;
  end

  // One sample: data_ready high for cycles [0,hi), optional re-edge at re_at, optional MAC overflow at tap ovf_tap.
  task automatic sample(input int hi, input int re_at, input int ovf_tap, input bit ovf_out, input int ncyc);
    int last = ovf_tap >= 0 ? ovf_tap : N - 1;
    exp_q.push_back(mk(3'd1, 2'd0, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(mk(3'd2, 2'd0, 1'b0, 1'b1, 1'b0));
    for (int t = 0; t <= last; t++) exp_q.push_back(mk(3'd3, t[1:0], 1'b0, 1'b1, 1'b0));
    if (ovf_tap >= 0) exp_q.push_back(mk(3'd0, 2'd0, 1'b0, 1'b0, 1'b1));
    else exp_q.push_back(mk(3'd4, 2'd0, 1'b0, 1'b1, 1'b0));
    exp_cnt++;
    for (int c = 0; c < ncyc; c++) begin
      data_ready = c < hi || (re_at >= 0 && c >= re_at && c < re_at + 2);
      overflow = (ovf_tap >= 0 && c == 3 + ovf_tap) || (ovf_out && (c == 1 || c == 2 || c == 7));
      @(posedge clk); #1;
    end
    data_ready = 0;
    overflow = 0;
  endtask

  initial begin
    #2 reset = 1;
    #1;
    check("reset_op", 32'(op), 32'd0);
    check("reset_tap", 32'(tap_sel), 32'd0);
    check("reset_cnt_up", 32'(cnt_up), 32'd0);
    check("reset_modwait", 32'(modwait), 32'd0);
    check("reset_err", 32'(err), 32'd0);
`ifdef SAMPLE_DROP_CNT_EN
    check("reset_dropped", 32'(dropped_cnt), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(posedge clk); #1;
    sample(20, -1, -1, 0, 22);
    sample(2, -1, 2, 0, 10);
    sample(2, -1, -1, 0, 10);
    sample(2, -1, 3, 0, 10);
    sample(2, -1, -1, 1, 10);
    data_ready = 1;
    exp_q.push_back(mk(3'd1, 2'd0, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(mk(3'd2, 2'd0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(3'd3, 2'd0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(3'd3, 2'd1, 1'b0, 1'b1, 1'b0));
    exp_cnt++;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1 reset = 1;
    #1;
    check("midrun_reset_op", 32'(op), 32'd0);
    check("midrun_reset_modwait", 32'(modwait), 32'd0);
    check("midrun_reset_tap", 32'(tap_sel), 32'd0);
    check("midrun_reset_err", 32'(err), 32'd0);
    check("midrun_reset_cnt_up", 32'(cnt_up), 32'd0);
    @(posedge clk);
    #1 reset = 0;
    data_ready = 0;
    repeat (10) begin @(posedge clk); #1; end
    check("midrun_reset_no_store", 32'(exp_q.size()), 32'd0);
    sample(2, 4, -1, 0, 10);
`ifdef SAMPLE_DROP_CNT_EN
    check("dropped_mid_run", 32'(dropped_cnt), 32'd1);
`endif
    sample(2, 7, -1, 0, 10);
`ifdef SAMPLE_DROP_CNT_EN
    check("dropped_at_store", 32'(dropped_cnt), 32'd2);
`endif
    for (int i = 0; i < 1000; i++) sample(5, -1, -1, 0, 10);
    repeat (5) begin @(posedge clk); #1; end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("cnt_up_total", 32'(n_cnt), 32'(exp_cnt));
`ifdef SAMPLE_DROP_CNT_EN
    check("dropped_final", 32'(dropped_cnt), 32'd2);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
